// File: rtl/img_sched_pkg.sv
// Shared types and constants for the live/background line-pair scheduler.
//   state_t  : scheduler FSM states
//   SRC_LIVE : m_tid value for a live (camera) line
//   SRC_BG   : m_tid value for a background (reconstructed) line
package img_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LIVE = 2'd1,
    ST_BG   = 2'd2
  } state_t;

  localparam logic SRC_LIVE = 1'b0;
  localparam logic SRC_BG   = 1'b1;

endpackage

// File: rtl/img_col_row_counter.sv
// Column/row position tracker for the line-pair scheduler.
// Ports:
//   Clock, Rst_n : clock, synchronous active-low reset
//   inc          : one accepted beat; advances the column
//   row_adv      : on a last-column beat, also advance the row (background line)
//   clear        : return both counters to 0
//   col, row     : current position
//   last_col     : col == IMG_W-1
//   last_row     : row == IMG_H-1
module img_col_row_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Rst_n,
  input  logic             inc,
  input  logic             row_adv,
  input  logic             clear,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last_col,
  output logic             last_row
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);

  assign last_col = (col == COL_MAX);
  assign last_row = (row == ROW_MAX);

  always_ff @(posedge Clock) begin
    if (!Rst_n || clear) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (last_col) begin
        col <= '0;
        // The row only moves once both lines of the pair have been sent.
        if (row_adv) row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/img_line_pair_scheduler.sv
// Interleaves a live camera stream (s0) and a background stream (s1) line by
// line onto one AXI-stream output: live row y, then background row y.
// Framing (tlast/tuser) comes from internal counters; source tlast is only
// checked and reported through len_err.
// Ports:
//   Clock, Rst_n      : clock, synchronous active-low reset
//   enable            : level; a new frame may start while high
//   s0_*              : live source (tvalid/tready/tdata/tlast)
//   s1_*              : background source (tvalid/tready/tdata/tlast)
//   m_*               : scheduled output stream; m_tid 0 = live, 1 = background
//   busy              : frame in progress
//   frame_done        : pulse the cycle after the last beat of a frame
//   len_err           : pulse with a beat whose source tlast disagrees with the column
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | no frame active, nothing passes, wait for enable
// LIVE    | forwarding live line of current row from s0
// BG      | forwarding background line of current row from s1
module img_line_pair_scheduler
  import img_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Rst_n,
  input  logic              enable,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tlast,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              m_tid,
  output logic              busy,
  output logic              frame_done,
  output logic              len_err
);

  state_t           state, state_nxt;
  logic             sel_live, sel_bg, sel_tlast, beat;
  logic [CNT_W-1:0] col, row;
  logic             last_col, last_row;

  assign sel_live = (state == ST_LIVE);
  assign sel_bg   = (state == ST_BG);

  // Zero-latency mux; the unselected source always sees tready low, so the
  // scheduler never swaps to whichever source happens to be valid.
  assign m_tvalid  = (sel_live & s0_tvalid) | (sel_bg & s1_tvalid);
  assign s0_tready = sel_live & m_tready;
  assign s1_tready = sel_bg & m_tready;
  assign m_tdata   = sel_live ? s0_tdata : (sel_bg ? s1_tdata : '0);
  assign sel_tlast = (sel_live & s0_tlast) | (sel_bg & s1_tlast);
  assign m_tid     = sel_bg ? SRC_BG : SRC_LIVE;

  assign beat    = m_tvalid & m_tready;
  assign m_tlast = (sel_live | sel_bg) & last_col;
  assign m_tuser = sel_live & (row == '0) & (col == '0);
  assign busy    = sel_live | sel_bg;
  assign len_err = beat & (sel_tlast != last_col);

  img_col_row_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clock    (Clock),
    .Rst_n    (Rst_n),
    .inc      (beat),
    .row_adv  (sel_bg),
    .clear    (state == ST_IDLE),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_ff @(posedge Clock) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= beat & sel_bg & last_col & last_row;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_LIVE;
      ST_LIVE: if (beat && last_col) state_nxt = ST_BG;
      ST_BG:   if (beat && last_col) state_nxt = last_row ? ST_IDLE : ST_LIVE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_img_line_pair_scheduler.sv
module tb_img_line_pair_scheduler;

  localparam int DATA_W = 32;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int CNT_W  = 16;

  logic              Clock, Rst_n, enable;
  logic              s0_tvalid, s0_tready, s0_tlast;
  logic              s1_tvalid, s1_tready, s1_tlast;
  logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
  logic              m_tvalid, m_tready, m_tlast, m_tuser, m_tid;
  logic              busy, frame_done, len_err;

  img_line_pair_scheduler #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Rst_n(Rst_n), .enable(enable),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tid(m_tid), .busy(busy), .frame_done(frame_done), .len_err(len_err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic        en;
    logic        exp_v;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_user;
    logic        exp_tid;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_r0;
    logic        exp_r1;
  } vec_t;

  vec_t vecs[19];
  int   checks = 0;
  int   errors = 0;
  int   n0 = 0;
  int   n1 = 0;

  function automatic vec_t mk(logic en, logic v, logic [31:0] d, logic l, logic u,
                              logic t, logic b, logic dn, logic r0, logic r1);
    vec_t x;
    x.en = en; x.exp_v = v; x.exp_data = d; x.exp_last = l; x.exp_user = u;
    x.exp_tid = t; x.exp_busy = b; x.exp_done = dn; x.exp_r0 = r0; x.exp_r1 = r1;
    return x;
  endfunction

  // Expected data of output beat b within one frame, both sources starting at n=0.
  function automatic logic [31:0] exp_data(int b);
    int base;
    base = ((b / 4) % 2 == 1) ? 32'h200 : 32'h100;
    return 32'(base + (b / 8) * 4 + (b % 4));
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source model: data counts accepted beats; tlast correct unless index hits bad*.
  task automatic drive_sources(int bad0, int bad1);
    s0_tdata = 32'h100 + 32'(n0);
    s1_tdata = 32'h200 + 32'(n1);
    s0_tlast = ((n0 % 4) == 3) ^ (n0 == bad0);
    s1_tlast = ((n1 % 4) == 3) ^ (n1 == bad1);
  endtask

  task automatic tick();
    bit a0, a1;
    a0 = s0_tvalid & s0_tready;
    a1 = s1_tvalid & s1_tready;
    @(posedge Clock);
    if (a0) n0++;
    if (a1) n1++;
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; enable = 1'b0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;
    n0 = 0; n1 = 0;
    drive_sources(-1, -1);
    repeat (2) @(posedge Clock);
    #1;
    Rst_n = 1'b1;
    n0 = 0; n1 = 0;
  endtask

  task automatic run_frame(string tag, bit toggle, int bad0, int bad1, int drop_after);
    int  beats = 0;
    int  cyc = 0;
    bit  done = 0;
    bit  ev, eerr;
    enable = 1'b1; s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    while (!done && cyc < 100) begin
      m_tready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (drop_after >= 0 && beats > drop_after) enable = 1'b0;
      drive_sources(bad0, bad1);
      #1;
      ev = (cyc > 0) && (beats < 16);
      chk1({tag, "_tvalid"}, m_tvalid, ev);
      if (ev) begin
        chk32({tag, "_tdata"}, m_tdata, exp_data(beats));
        chk1({tag, "_tlast"}, m_tlast, (beats % 4) == 3);
        chk1({tag, "_tuser"}, m_tuser, beats == 0);
        chk1({tag, "_tid"}, m_tid, (beats / 4) % 2 == 1);
      end
      eerr = ev && m_tready && (((beats / 4) % 2 == 0) ? (n0 == bad0) : (n1 == bad1));
      chk1({tag, "_len_err"}, len_err, eerr);
      chk1({tag, "_frame_done"}, frame_done, beats == 16);
      if (beats == 16) begin
        chk1({tag, "_busy_end"}, busy, 1'b0);
        done = 1;
      end
      if (ev && m_tready) beats++;
      tick();
      cyc++;
    end
    if (!done) chk1({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 32'h100, 0, 1, 0, 1, 0, 1, 0);
    vecs[2]  = mk(1, 1, 32'h101, 0, 0, 0, 1, 0, 1, 0);
    vecs[3]  = mk(1, 1, 32'h102, 0, 0, 0, 1, 0, 1, 0);
    vecs[4]  = mk(1, 1, 32'h103, 1, 0, 0, 1, 0, 1, 0);
    vecs[5]  = mk(1, 1, 32'h200, 0, 0, 1, 1, 0, 0, 1);
    vecs[6]  = mk(1, 1, 32'h201, 0, 0, 1, 1, 0, 0, 1);
    vecs[7]  = mk(1, 1, 32'h202, 0, 0, 1, 1, 0, 0, 1);
    vecs[8]  = mk(1, 1, 32'h203, 1, 0, 1, 1, 0, 0, 1);
    vecs[9]  = mk(1, 1, 32'h104, 0, 0, 0, 1, 0, 1, 0);
    vecs[10] = mk(1, 1, 32'h105, 0, 0, 0, 1, 0, 1, 0);
    vecs[11] = mk(1, 1, 32'h106, 0, 0, 0, 1, 0, 1, 0);
    vecs[12] = mk(1, 1, 32'h107, 1, 0, 0, 1, 0, 1, 0);
    vecs[13] = mk(1, 1, 32'h204, 0, 0, 1, 1, 0, 0, 1);
    vecs[14] = mk(1, 1, 32'h205, 0, 0, 1, 1, 0, 0, 1);
    vecs[15] = mk(1, 1, 32'h206, 0, 0, 1, 1, 0, 0, 1);
    vecs[16] = mk(1, 1, 32'h207, 1, 0, 1, 1, 0, 0, 1);
    vecs[17] = mk(1, 0, 32'h0,   0, 0, 0, 0, 1, 0, 0);
    vecs[18] = mk(1, 1, 32'h108, 0, 1, 0, 1, 0, 1, 0);

    // Reset state
    do_reset();
    #1;
    chk1("rst_tvalid", m_tvalid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_s0_tready", s0_tready, 1'b0);
    chk1("rst_s1_tready", s1_tready, 1'b0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_len_err", len_err, 1'b0);
    chk32("rst_tdata", m_tdata, 32'h0);
    tick();

    // 1: full frame from the vector table, then back-to-back restart
    do_reset();
    s0_tvalid = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      enable = vecs[i].en;
      drive_sources(-1, -1);
      #1;
      chk1("t1_tvalid", m_tvalid, vecs[i].exp_v);
      chk1("t1_busy", busy, vecs[i].exp_busy);
      chk1("t1_frame_done", frame_done, vecs[i].exp_done);
      chk1("t1_s0_tready", s0_tready, vecs[i].exp_r0);
      chk1("t1_s1_tready", s1_tready, vecs[i].exp_r1);
      chk1("t1_len_err", len_err, 1'b0);
      if (vecs[i].exp_v) begin
        chk32("t1_tdata", m_tdata, vecs[i].exp_data);
        chk1("t1_tlast", m_tlast, vecs[i].exp_last);
        chk1("t1_tuser", m_tuser, vecs[i].exp_user);
        chk1("t1_tid", m_tid, vecs[i].exp_tid);
      end
      tick();
    end

    // 2: background source stalls; live source must not be consumed
    do_reset();
    enable = 1'b1; s0_tvalid = 1'b1; s1_tvalid = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_sources(-1, -1);
      #1;
      tick();
    end
    chk32("t2_live_line_beats", 32'(n0), 32'd4);
    for (int i = 0; i < 5; i++) begin
      drive_sources(-1, -1);
      #1;
      chk1("t2_tvalid_stall", m_tvalid, 1'b0);
      chk1("t2_s0_tready_stall", s0_tready, 1'b0);
      chk1("t2_s1_tready_stall", s1_tready, 1'b1);
      chk1("t2_tid_stall", m_tid, 1'b1);
      chk1("t2_busy_stall", busy, 1'b1);
      tick();
    end
    chk32("t2_s0_count_held", 32'(n0), 32'd4);
    s1_tvalid = 1'b1;
    drive_sources(-1, -1);
    #1;
    chk1("t2_tvalid_resume", m_tvalid, 1'b1);
    chk32("t2_tdata_resume", m_tdata, 32'h200);
    tick();
    chk32("t2_s1_count", 32'(n1), 32'd1);

    // 3: downstream ready toggling
    do_reset();
    run_frame("t3", 1'b1, -1, -1, -1);

    // 4: early tlast on live col 1 of row 0
    do_reset();
    run_frame("t4", 1'b0, 1, -1, -1);

    // 5: enable dropped after beat 2; frame completes, then stays idle
    do_reset();
    run_frame("t5", 1'b0, -1, -1, 2);
    for (int i = 0; i < 5; i++) begin
      drive_sources(-1, -1);
      #1;
      chk1("t5_idle_tvalid", m_tvalid, 1'b0);
      chk1("t5_idle_busy", busy, 1'b0);
      chk1("t5_idle_tuser", m_tuser, 1'b0);
      chk1("t5_idle_s0_tready", s0_tready, 1'b0);
      tick();
    end

    // 6: reset mid-frame after beat 6
    do_reset();
    enable = 1'b1; s0_tvalid = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 30 && (n0 + n1) < 7; i++) begin
      drive_sources(-1, -1);
      #1;
      tick();
    end
    chk32("t6_beats_before_rst", 32'(n0 + n1), 32'd7);
    Rst_n = 1'b0;
    drive_sources(-1, -1);
    tick();
    Rst_n = 1'b1;
    drive_sources(-1, -1);
    #1;
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_tvalid", m_tvalid, 1'b0);
    chk1("t6_rst_s0_tready", s0_tready, 1'b0);
    chk1("t6_rst_s1_tready", s1_tready, 1'b0);
    chk1("t6_rst_frame_done", frame_done, 1'b0);
    tick();
    drive_sources(-1, -1);
    #1;
    chk1("t6_sof_tvalid", m_tvalid, 1'b1);
    chk1("t6_sof_tuser", m_tuser, 1'b1);
    chk1("t6_sof_tid", m_tid, 1'b0);
    chk1("t6_sof_s0_tready", s0_tready, 1'b1);
    chk32("t6_sof_tdata", m_tdata, 32'h104);
    chk1("t6_sof_frame_done", frame_done, 1'b0);
    tick();

    // 7: wrong tlast on the very last beat -> len_err then frame_done
    do_reset();
    run_frame("t7", 1'b0, -1, 7, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
